// File: rtl/mc_sequencer_pkg.sv
// Shared definitions for the multi-cycle control sequencer: opcodes,
// the halt encoding, FSM state encoding and pc source selects.
package mc_sequencer_pkg;

  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_ADDI  = 3'b001;
  localparam logic [2:0] OP_LW    = 3'b010;
  localparam logic [2:0] OP_SW    = 3'b011;
  localparam logic [2:0] OP_BEQ   = 3'b100;
  localparam logic [2:0] OP_JMP   = 3'b101;

  localparam logic [15:0] HALT_INSTR = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT,
    S_ERR
  } state_e;

  typedef enum logic [1:0] {
    PC_INC    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2
  } pc_src_e;

  // Opcode 110 is never valid; 111 is only valid as the full halt word.
  function automatic logic isIllegal(input logic [15:0] instr);
    logic [2:0] op;
    op = instr[15:13];
    return (op == 3'b110) || ((op == 3'b111) && (instr != HALT_INSTR));
  endfunction

endpackage

// File: rtl/mc_mem_wait.sv
// Data-memory wait counter. Counts consecutive MEM cycles without a
// ready response and flags the cycle in which the budget runs out.
module mc_mem_wait #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TW          = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in_mem_i,
  input  logic mem_ready_i,
  output logic timeout_o
);

  // The counter holds the number of unanswered MEM cycles already seen,
  // so the last allowed cycle is the one where it equals MEM_TIMEOUT-1.
  localparam logic [TW-1:0] LastWait = TW'(MEM_TIMEOUT - 1);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  // Next count: step while waiting in MEM, clear on ready or when outside MEM.
  always_comb begin
    count_d = '0;
    if (in_mem_i && !mem_ready_i) begin
      count_d = count_q + TW'(1);
    end
  end

  // Wait counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign timeout_o = in_mem_i && !mem_ready_i && (count_q == LastWait);

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle control sequencer: fetch / decode / execute / mem / writeback
// for the 16-bit datapath, with a memory-ready timeout, halt and illegal
// opcode detection, and a retired-instruction counter.
module mc_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TW          = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] instruction,
  input  logic        is_zero,
  input  logic        mem_ready,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        ir_we,
  output logic        reg_we,
  output logic        reg_dest,
  output logic        alusrc,
  output logic        memtoreg,
  output logic        mem_req,
  output logic        mem_we,
  output logic        halted,
  output logic        err,
  output logic [15:0] retired
);

  import mc_sequencer_pkg::*;

  state_e      state_q;
  state_e      state_d;
  logic        retire_d;
  logic [15:0] retired_q;
  logic [2:0]  opcode;
  logic        inMem;
  logic        memTimeout;

  assign opcode = instruction[15:13];
  assign inMem  = (state_q == S_MEM);

  mc_mem_wait #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TW          (TW)
  ) u_mem_wait (
    .clk         (clk),
    .rst         (rst),
    .in_mem_i    (inMem),
    .mem_ready_i (mem_ready),
    .timeout_o   (memTimeout)
  );

  // Next-state selection and retire detection for every state.
  always_comb begin
    state_d  = state_q;
    retire_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (instruction == HALT_INSTR) state_d = S_HALT;
        else if (isIllegal(instruction)) state_d = S_ERR;
        else state_d = S_EXEC;
      end
      S_EXEC: begin
        case (opcode)
          OP_RTYPE, OP_ADDI: state_d = S_WB;
          OP_LW, OP_SW:      state_d = S_MEM;
          OP_BEQ, OP_JMP: begin
            state_d  = S_FETCH;
            retire_d = 1'b1;
          end
          default:           state_d = S_ERR;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (opcode == OP_SW) begin
            state_d  = S_FETCH;
            retire_d = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end else if (memTimeout) begin
          state_d = S_ERR;
        end
      end
      S_WB: begin
        state_d  = S_FETCH;
        retire_d = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  // State register and retired counter; reset aborts any instruction at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire_d) retired_q <= retired_q + 16'd1;
    end
  end

  // Output decode from the current state; only the beq pc write looks at is_zero.
  always_comb begin
    pc_we    = 1'b0;
    pc_src   = PC_INC;
    ir_we    = 1'b0;
    reg_we   = 1'b0;
    reg_dest = 1'b0;
    alusrc   = 1'b0;
    memtoreg = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    halted   = 1'b0;
    err      = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_we  = 1'b1;
        pc_we  = 1'b1;
        pc_src = PC_INC;
      end
      S_EXEC: begin
        alusrc = (opcode == OP_ADDI) || (opcode == OP_LW) || (opcode == OP_SW);
        if (opcode == OP_BEQ) begin
          pc_we  = is_zero;
          pc_src = PC_BRANCH;
        end else if (opcode == OP_JMP) begin
          pc_we  = 1'b1;
          pc_src = PC_JUMP;
        end
      end
      S_MEM: begin
        alusrc  = 1'b1;
        mem_req = 1'b1;
        mem_we  = (opcode == OP_SW);
      end
      S_WB: begin
        reg_we   = 1'b1;
        reg_dest = (opcode == OP_RTYPE);
        alusrc   = (opcode == OP_ADDI) || (opcode == OP_LW);
        memtoreg = (opcode == OP_LW);
      end
      S_HALT:  halted = 1'b1;
      S_ERR:   err    = 1'b1;
      default: ;
    endcase
  end

  assign retired = retired_q;

endmodule
